// File: rtl/packed_ser_pkg.sv
// Shared state type and sizing helpers for the packed bit serializer.
package packed_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int beats(input int width, input int beat_w);
        return width / beat_w;
    endfunction

    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/packed_bit_serializer.sv
// Parallel-to-serial converter: one WIDTH-bit word out as BEAT_W-bit beats,
// each tagged with the bit index of its LSB and a last flag.
//
// state | meaning
// IDLE  | no word held, in_ready high
// SHIFT | presenting beat k of the latched word
module packed_bit_serializer
    import packed_ser_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int BEAT_W = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_msb_first,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BEAT_W-1:0]              out_data,
    output logic [idx_width(WIDTH)-1:0]    out_idx,
    output logic                           out_last
);

    localparam int BEATS = beats(WIDTH, BEAT_W);
    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = idx_width(BEATS);

    if (WIDTH < 1 || BEAT_W < 1 || (WIDTH % BEAT_W) != 0) begin : g_param_check
        $error("packed_bit_serializer: BEAT_W must be >= 1 and divide WIDTH");
    end

    ser_state_e         state_q, state_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               msb_q, msb_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               valid_q, valid_d;
    logic [BEAT_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               accept;
    logic               xfer;
    int                 shift;

    always_comb begin
        in_ready = (state_q == IDLE) || (valid_q && out_ready && last_q);
        accept   = in_valid && in_ready;
        xfer     = valid_q && out_ready;

        state_d = state_q;
        word_d  = word_q;
        msb_d   = msb_q;
        k_d     = k_q;
        valid_d = valid_q;

        if (accept) begin
            state_d = SHIFT;
            word_d  = in_data;
            msb_d   = in_msb_first;
            k_d     = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end

        // The beat's bit index doubles as the shift amount for both orders.
        shift  = msb_d ? (WIDTH - BEAT_W - int'(k_d) * BEAT_W) : int'(k_d) * BEAT_W;
        data_d = '0;
        idx_d  = '0;
        last_d = 1'b0;
        if (valid_d) begin
            data_d = BEAT_W'(word_d >> shift);
            idx_d  = IDX_W'(shift);
            last_d = (k_d == CNT_W'(BEATS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            msb_q   <= 1'b0;
            k_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            msb_q   <= msb_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_packed_bit_serializer.sv
// Bench for packed_bit_serializer: a BEAT_W=1 and a BEAT_W=4 instance share
// stimulus; a monitor feeds expected/observed beat queues that each test drains.
module tb_packed_bit_serializer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_msb_first;
    logic          out_ready;
    logic          use_b;

    logic          a_in_ready, a_out_valid, a_out_data, a_out_last;
    logic [3:0]    a_out_idx;
    logic          b_in_ready, b_out_valid, b_out_last;
    logic [3:0]    b_out_data, b_out_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];

    always #5 clk = ~clk;

    packed_bit_serializer #(.WIDTH(W), .BEAT_W(1)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_msb_first(in_msb_first),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last)
    );

    packed_bit_serializer #(.WIDTH(W), .BEAT_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_msb_first(in_msb_first),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last)
    );

    wire       m_ready = use_b ? b_in_ready  : a_in_ready;
    wire       m_valid = use_b ? b_out_valid : a_out_valid;
    wire [3:0] m_data  = use_b ? b_out_data  : {3'b000, a_out_data};
    wire [3:0] m_idx   = use_b ? b_out_idx   : a_out_idx;
    wire       m_last  = use_b ? b_out_last  : a_out_last;

    task automatic push_word(input logic [W-1:0] w, input logic msb, input int bw);
        int    n, idx;
        beat_t e;
        n = W / bw;
        for (int k = 0; k < n; k++) begin
            idx    = msb ? (W - bw - k * bw) : k * bw;
            e.data = '0;
            for (int b = 0; b < bw; b++) e.data[b] = w[idx + b];
            e.idx  = 4'(idx);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (in_valid && m_ready) push_word(in_data, in_msb_first, use_b ? 4 : 1);
            if (m_valid && out_ready) obs_q.push_back('{m_data, m_idx, m_last});
        end
    end

    task automatic send(input logic [W-1:0] w, input logic msb);
        @(negedge clk);
        in_valid     = 1'b1;
        in_data      = w;
        in_msb_first = msb;
        @(negedge clk);
        in_valid     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            #3;
            if (!a_out_valid && !b_out_valid) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout: outputs still valid after 64 cycles, expected idle", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0;
        out_ready = 1'b1; use_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if ({a_out_valid, a_out_data, a_out_idx, a_out_last, a_in_ready} !== 8'b0_0_0000_0_1) begin
            failures++;
            $display("FAIL reset_a: got v=%b d=%b i=%0d l=%b rdy=%b, expected 0 0 0 0 1",
                     a_out_valid, a_out_data, a_out_idx, a_out_last, a_in_ready);
        end
        checks++;
        if ({b_out_valid, b_out_data, b_out_idx, b_out_last, b_in_ready} !== 11'b0_0000_0000_0_1) begin
            failures++;
            $display("FAIL reset_b: got v=%b d=%h i=%0d l=%b rdy=%b, expected 0 0 0 0 1",
                     b_out_valid, b_out_data, b_out_idx, b_out_last, b_in_ready);
        end
    endtask

    task automatic test_bit_order_b1();
        logic [15:0] seq;
        beat_t       o, e;
        logic [15:0] want [2] = '{16'h10FA, 16'h5F08};
        use_b = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            send(16'h10FA, (pass == 0));
            wait_idle("b1_order");
            seq = '0;
            for (int i = 0; i < obs_q.size() && i < 16; i++) seq = {seq[14:0], obs_q[i].data[0]};
            checks++;
            if (obs_q.size() != 16 || seq !== want[pass]) begin
                failures++;
                $display("FAIL b1_seq pass%0d: got %0d beats bits=%h, expected 16 beats bits=%h",
                         pass, obs_q.size(), seq, want[pass]);
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL b1_beat pass%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                             pass, o.data, o.idx, o.last, e.data, e.idx, e.last);
                end
            end
            checks++;
            if (obs_q.size() != 0 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL b1_count pass%0d: leftover obs=%0d exp=%0d, expected 0/0",
                         pass, obs_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_beats_b4();
        logic [15:0] dseq, iseq;
        beat_t       o, e;
        logic [15:0] want_d [2] = '{16'h10FA, 16'hAF01};
        logic [15:0] want_i [2] = '{16'hC840, 16'h048C};
        use_b = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            send(16'h10FA, (pass == 0));
            wait_idle("b4_order");
            dseq = '0; iseq = '0;
            for (int i = 0; i < obs_q.size() && i < 4; i++) begin
                dseq = {dseq[11:0], obs_q[i].data};
                iseq = {iseq[11:0], obs_q[i].idx};
            end
            checks++;
            if (obs_q.size() != 4 || dseq !== want_d[pass] || iseq !== want_i[pass]) begin
                failures++;
                $display("FAIL b4_seq pass%0d: got %0d beats data=%h idx=%h, expected 4 beats data=%h idx=%h",
                         pass, obs_q.size(), dseq, iseq, want_d[pass], want_i[pass]);
            end
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL b4_beat pass%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                             pass, o.data, o.idx, o.last, e.data, e.idx, e.last);
                end
            end
            checks++;
            if (obs_q.size() != 0 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL b4_count pass%0d: leftover obs=%0d exp=%0d, expected 0/0",
                         pass, obs_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] hd, hi;
        logic       hl;
        beat_t      o, e;
        use_b = 1'b0;
        send(16'hA5C3, 1'b1);
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        #3;
        hd = m_data; hi = m_idx; hl = m_last;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) out_ready = 1'b1;
            #3;
            checks++;
            if ({m_valid, m_data, m_idx, m_last, m_ready} !== {1'b1, hd, hi, hl, 1'b0}) begin
                failures++;
                $display("FAIL stall%0d: got v=%b d=%h i=%0d l=%b rdy=%b, expected 1 %h %0d %b 0",
                         i, m_valid, m_data, m_idx, m_last, m_ready, hd, hi, hl);
            end
        end
        wait_idle("stall");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall_beat: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                         o.data, o.idx, o.last, e.data, e.idx, e.last);
            end
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_count: leftover obs=%0d exp=%0d, expected 0/0", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dseq;
        beat_t       o, e;
        use_b = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h10FA; in_msb_first = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin in_data = 16'h3C5A; in_msb_first = 1'b0; end
            if (c == 5) in_valid = 1'b0;
            #3;
            checks++;
            if (m_valid !== (c <= 8) || m_ready !== (c == 4 || c == 8 || c == 9)) begin
                failures++;
                $display("FAIL b2b cycle%0d: got v=%b rdy=%b, expected v=%b rdy=%b",
                         c, m_valid, m_ready, (c <= 8), (c == 4 || c == 8 || c == 9));
            end
        end
        dseq = '0;
        for (int i = 0; i < obs_q.size() && i < 8; i++) dseq = {dseq[27:0], obs_q[i].data};
        checks++;
        if (obs_q.size() != 8 || dseq !== 32'h10FA_A5C3) begin
            failures++;
            $display("FAIL b2b_seq: got %0d beats data=%h, expected 8 beats data=10faa5c3", obs_q.size(), dseq);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b_beat: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                         o.data, o.idx, o.last, e.data, e.idx, e.last);
            end
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: leftover obs=%0d exp=%0d, expected 0/0", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        beat_t o, e;
        use_b = 1'b0;
        send(16'h6B2D, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++;
        if ({a_out_valid, a_in_ready, a_out_last} !== 3'b010) begin
            failures++;
            $display("FAIL rst_mid: got v=%b rdy=%b l=%b, expected 0 1 0", a_out_valid, a_in_ready, a_out_last);
        end
        checks++;
        if (obs_q.size() != 7) begin
            failures++;
            $display("FAIL rst_mid_count: got %0d beats before reset, expected 7", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_mid_beat: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                         o.data, o.idx, o.last, e.data, e.idx, e.last);
            end
        end
        exp_q.delete();
        obs_q.delete();
        send(16'h00FF, 1'b0);
        wait_idle("rst_next");
        checks++;
        if (obs_q.size() == 0 || obs_q[0].idx !== 4'd0 || obs_q[0].data !== 4'd1) begin
            failures++;
            $display("FAIL rst_next_first: got %0d beats, first idx/data wrong, expected idx=0 data=1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_next_beat: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                         o.data, o.idx, o.last, e.data, e.idx, e.last);
            end
        end
        checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_next_count: leftover obs=%0d exp=%0d, expected 0/0", obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_bit_order_b1();
        test_beats_b4();
        test_backpressure();
        test_back_to_back();
        wait_idle("pre_rst_mid");
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/packed_bit_serializer.md
# packed_bit_serializer

Parametrised parallel-to-serial converter for packed vectors. It accepts a WIDTH-bit packed word over a valid/ready handshake and emits it as WIDTH/BEAT_W beats of BEAT_W bits each. Each beat is tagged with the bit index of its lowest bit and a last flag. Bit order is selectable per word: MSB-first (descending index) or LSB-first (ascending index). The block sits between a word-wide producer and a narrow serial consumer, such as a debug or trace port or a bit-level monitor.

## Interface
- WIDTH, 16, packed word width in bits; must be ≥ 1.
- BEAT_W, 1, bits per output beat; must divide WIDTH exactly (elaboration-time assertion).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  packed word, sampled on the accept edge.
- in_msb_first  input  1  bit order for this word, sampled with in_data: 1 = descending, 0 = ascending.
- out_valid  output  1  a beat is presented.
- out_ready  input  1  consumer takes the beat.
- out_data  output  BEAT_W  current beat.
- out_idx  output  $clog2(WIDTH) (minimum 1)  bit index in in_data of out_data[0].
- out_last  output  1  current beat is the final beat of the word.

## Operation
- Derived constant: BEATS = WIDTH/BEAT_W.
- State machine with two states: IDLE and SHIFT. Reset enters IDLE.
- Accept condition: in_valid && in_ready.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). It is combinational from registered state plus out_ready, which allows zero-bubble back-to-back words.
- On accept:
  - Latch in_data and in_msb_first.
  - Clear the beat counter k.
  - Set out_valid = 1 and move to SHIFT.
- Beat k, MSB-first:
  - out_data = word[WIDTH-1-k*BEAT_W -: BEAT_W]
  - out_idx = WIDTH-BEAT_W-k*BEAT_W
- Beat k, LSB-first:
  - out_data = word[k*BEAT_W +: BEAT_W]
  - out_idx = k*BEAT_W
- out_last = (k == BEATS-1).
- Beat transfer condition: out_valid && out_ready.
  - Not last: k advances by 1.
  - Last, no new accept in the same cycle: return to IDLE and set out_valid = 0.
  - Last, with a simultaneous accept: stay in SHIFT, load the new word, set k = 0, keep out_valid = 1.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. The latched word is never modified.
- BEATS == 1: every beat is last, and one word per cycle is sustained.
- in_data and in_msb_first are ignored outside the accept cycle. A change to in_msb_first mid-word has no effect on that word.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - in_ready = 1 from the first cycle after reset, since the block is in IDLE.
- Latency: a word accepted at edge N has beat 0 visible after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle with no backpressure. A word occupies exactly BEATS cycles, with no idle cycle between words.
- Reset mid-word: the word is discarded, with no further beats and no out_last. Outputs take their reset values at the reset edge.
- All outputs except in_ready are registered.

## Structure
- Package packed_ser_pkg holds:
  - the state enum typedef ser_state_e (IDLE, SHIFT);
  - a function beats(width, beat_w) returning width/beat_w;
  - an index-width helper returning max(1, $clog2(width)).
- Single module, no sub-modules. The counter, word register and slice mux are all inline.

## Test plan
- WIDTH=16, BEAT_W=1, word 16'h10FA, MSB-first, out_ready=1:
  - out_data sequence 0,0,0,1, 0,0,0,0, 1,1,1,1, 1,0,1,0.
  - out_idx runs 15→0; out_last only at idx 0.
- Same word, LSB-first:
  - out_data sequence 0,1,0,1, 1,1,1,1, 0,0,0,0, 1,0,0,0.
  - out_idx runs 0→15; out_last only at idx 15.
- WIDTH=16, BEAT_W=4, word 16'h10FA:
  - MSB-first gives beats 1,0,F,A with idx 12,8,4,0.
  - LSB-first gives beats A,F,0,1 with idx 0,4,8,12.
- Backpressure:
  - Drop out_ready for 3 cycles at beat 5. out_data, out_idx and out_last hold stable, and in_ready stays 0.
  - The sequence resumes intact.
- Back-to-back:
  - Two words, in_valid held high. in_ready pulses high in the last-beat cycle.
  - Beat 0 of word 2 follows the last beat of word 1 with no gap, using its own bit order.
- Reset mid-word:
  - Assert rst at beat 7 for 1 cycle. The next cycle shows out_valid=0 and in_ready=1.
  - The next word starts at k=0.
